// File: rtl/gigex_tx_arbiter_if.sv
// Bundles the requester byte streams and the GigEx user transmit pins.
// The arbiter connects through `master`; the side that drives requests and nTF connects through `slave`.
interface gigex_tx_arbiter_if #(
    parameter int NCH = 4
);
    // A requester byte moves on any cycle where both s_valid[i] and s_ready[i] are high.
    // s_ready[i] does not depend on s_valid[i]. A requester may lower s_valid at any time.
    logic [NCH-1:0]   s_valid;
    logic [8*NCH-1:0] s_data;
    logic [NCH-1:0]   s_last;
    logic [NCH-1:0]   s_ready;
    logic [7:0]       nTF;
    logic [7:0]       D;
    logic             nTx;
    logic [2:0]       TC;

    modport master (
        input  s_valid, s_data, s_last, nTF,
        output s_ready, D, nTx, TC
    );

    modport slave (
        output s_valid, s_data, s_last, nTF,
        input  s_ready, D, nTx, TC
    );
endinterface

// File: rtl/gigex_tx_arbiter.sv
// Round-robin, burst-limited sharing of the GigEx user transmit port.
// Requester i only writes to channel TC=i, and each channel has its own full-flag backpressure.
module gigex_tx_arbiter #(
    parameter int NCH       = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     tx_en,
    gigex_tx_arbiter_if.master       bus,
    output logic [NCH-1:0]           grant,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      d_q, d_d;
    logic            ntx_q, ntx_d;
    logic [2:0]      tc_q, tc_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [7:0]      ntf_q, ntf_d;

    logic            own_valid;
    logic            own_last;
    logic [7:0]      own_data;
    logic            own_ready;
    logic            own_hs;
    logic            burst_end;
    logic            exit_grant;

    logic [7:0]      elig;
    logic            found;
    logic [2:0]      pick;

    // The GigEx FIFO absorbs two writes after nTF falls, so every decision uses the registered copy.
    assign ntf_d = bus.nTF;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int i = 0; i < NCH; i++) begin
            if (tc_q == 3'(i)) begin
                own_valid = bus.s_valid[i];
                own_last  = bus.s_last[i];
                own_data  = bus.s_data[8*i +: 8];
            end
        end
    end

    assign own_ready  = (state_q == GRANT) && ntf_q[tc_q] && (cnt_q < CW'(MAX_BURST));
    assign own_hs     = own_valid && own_ready;
    assign burst_end  = (cnt_q == CW'(MAX_BURST - 1));
    assign exit_grant = (own_hs && (own_last || burst_end)) || !own_valid || !ntf_q[tc_q];

    always_comb begin
        bus.s_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.s_ready[i] = own_ready && (tc_q == 3'(i));
        end
    end

    // The search starts just after the previous owner, so the last winner is checked last.
    always_comb begin
        elig  = 8'h00;
        found = 1'b0;
        pick  = ptr_q;
        for (int i = 0; i < NCH; i++) begin
            elig[i] = bus.s_valid[i] & ntf_q[i];
        end
        for (int k = 1; k <= NCH; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NCH;
            if (!found && elig[idx[2:0]]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        ntx_d   = 1'b1;
        tc_d    = tc_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (tx_en && found) begin
                    state_d = GRANT;
                    tc_d    = pick;
                    ptr_d   = pick;
                    cnt_d   = '0;
                    for (int i = 0; i < NCH; i++) begin
                        grant_d[i] = (pick == 3'(i));
                    end
                end
            end
            GRANT: begin
                if (own_hs) begin
                    d_d   = own_data;
                    ntx_d = 1'b0;
                    cnt_d = cnt_q + 1'b1;
                end
                if (exit_grant) begin
                    state_d = GAP;
                    grant_d = '0;
                end
            end
            GAP: begin
                // TC is held here, so the pins always see one idle strobe before TC can move.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= 8'h00;
            ntx_q   <= 1'b1;
            tc_q    <= 3'd0;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= 3'(NCH - 1);
            ntf_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            ntx_q   <= ntx_d;
            tc_q    <= tc_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ntf_q   <= ntf_d;
        end
    end

    assign bus.D     = d_q;
    assign bus.nTx   = ntx_q;
    assign bus.TC    = tc_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gigex_tx_arbiter.sv
// Bench for gigex_tx_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level reference model and a write scoreboard.
module tb_gigex_tx_arbiter;

    localparam int NCH       = 4;
    localparam int MAX_BURST = 16;

    logic           sys_clk = 1'b0;
    logic           rst_n   = 1'b1;
    logic           tx_en   = 1'b1;
    logic [NCH-1:0] grant;
    logic           busy;
    logic [1:0]     dbg_state;

    gigex_tx_arbiter_if #(.NCH(NCH)) bus();

    gigex_tx_arbiter #(.NCH(NCH), .MAX_BURST(MAX_BURST)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .bus       (bus),
        .grant     (grant),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int             m_owner;
    int             m_ptr;
    int             m_cnt;
    bit             m_gap;
    logic [7:0]     m_ntfq;
    logic [7:0]     m_D;
    logic           m_nTx;
    logic [2:0]     m_TC;
    logic [NCH-1:0] m_hs;
    logic [10:0]    exp_q[$];

    function automatic logic [NCH-1:0] m_ready();
        logic [NCH-1:0] r;
        r = '0;
        if (m_owner >= 0 && m_ntfq[m_owner] && m_cnt < MAX_BURST) r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        logic [NCH-1:0] rdy;
        logic           hs;
        logic [7:0]     b;
        int             o;
        rdy   = m_ready();
        m_hs  = '0;
        m_nTx = 1'b1;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            if (tx_en) begin
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_ptr + k) % NCH;
                    if (bus.s_valid[c] && m_ntfq[c]) begin
                        m_owner = c;
                        m_ptr   = c;
                        m_TC    = 3'(c);
                        m_cnt   = 0;
                        break;
                    end
                end
            end
        end else begin
            o  = m_owner;
            hs = bus.s_valid[o] && rdy[o];
            if (hs) begin
                b       = bus.s_data[8*o +: 8];
                m_D     = b;
                m_nTx   = 1'b0;
                m_hs[o] = 1'b1;
                exp_q.push_back({3'(o), b});
            end
            if ((hs && (bus.s_last[o] || m_cnt == MAX_BURST - 1)) || !bus.s_valid[o] || !m_ntfq[o]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end
            if (hs) m_cnt++;
        end
        m_ntfq = bus.nTF;
    endtask

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = NCH - 1;
            m_cnt   = 0;
            m_gap   = 1'b0;
            m_ntfq  = 8'hFF;
            m_D     = 8'h00;
            m_nTx   = 1'b1;
            m_TC    = 3'd0;
            m_hs    = '0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // ---------------- compare / scoreboard ----------------
    bit         chk_en = 1'b0;
    bit         prev_ok = 1'b0;
    logic [2:0] prev_tc;
    logic       prev_ntx;

    always @(posedge sys_clk) begin
        logic [10:0] e;
        #1;
        if (rst_n && chk_en) begin
            check("nTx", 32'(bus.nTx), 32'(m_nTx));
            check("D", 32'(bus.D), 32'(m_D));
            check("TC", 32'(bus.TC), 32'(m_TC));
            check("grant", 32'(grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
            check("busy", 32'(busy), (m_owner >= 0 || m_gap) ? 32'd1 : 32'd0);
            check("s_ready", 32'(bus.s_ready), 32'(m_ready()));
            if (!bus.nTx) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_write: write TC=%0d D=%0h with no accepted byte pending", bus.TC, bus.D);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_write", 32'({bus.TC, bus.D}), 32'(e));
                end
            end
            if (prev_ok && bus.TC != prev_tc) check("tc_idle_before", 32'(prev_ntx), 32'd1);
            prev_tc  = bus.TC;
            prev_ntx = bus.nTx;
            prev_ok  = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
    end

    // ---------------- driver ----------------
    logic [NCH-1:0] cont_mask = '0;
    bit             rnd_en = 1'b0;
    logic [7:0]     nb [NCH];

    task automatic tick();
        @(posedge sys_clk);
        #2;
        for (int i = 0; i < NCH; i++) begin
            if (cont_mask[i]) begin
                if (m_hs[i] || !bus.s_valid[i]) begin
                    bus.s_valid[i]      = 1'b1;
                    bus.s_data[8*i +: 8] = nb[i];
                    nb[i]++;
                    bus.s_last[i]       = 1'b0;
                end
            end else if (rnd_en) begin
                if (bus.s_valid[i] && !m_hs[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.s_valid[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 60) begin
                    bus.s_valid[i]       = 1'b1;
                    bus.s_data[8*i +: 8] = nb[i];
                    nb[i]++;
                    bus.s_last[i]        = ($urandom_range(0, 5) == 0);
                end else begin
                    bus.s_valid[i] = 1'b0;
                end
            end
        end
        if (rnd_en) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.nTF[b] && $urandom_range(0, 19) == 0) bus.nTF[b] = 1'b0;
                else if (!bus.nTF[b] && $urandom_range(0, 4) == 0) bus.nTF[b] = 1'b1;
            end
            tx_en = ($urandom_range(0, 15) != 0);
        end
    endtask

    function automatic int oh2i(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_fresh(input int budget, output int owner);
        logic [NCH-1:0] pg;
        owner = -1;
        pg    = grant;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (grant != 0 && pg == 0) begin
                owner = oh2i(grant);
                return;
            end
            pg = grant;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_grant: no new grant within %0d cycles", budget);
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #2;
        rst_n       = 1'b0;
        bus.s_valid = '0;
        bus.s_last  = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         o;
        int         nxt;
        int         w;
        int         extra;
        int         h2;
        bit         seen;
        logic [NCH-1:0] pg;
        int         owners[$];
        int         wr[8];
        logic       log_n[8];
        logic [7:0] log_d[8];
        logic [NCH-1:0] log_g[8];
        logic       log_b[8];

        bus.s_valid = '0;
        bus.s_data  = '0;
        bus.s_last  = '0;
        bus.nTF     = 8'hFF;
        for (int i = 0; i < NCH; i++) nb[i] = 8'(i * 64);

        #2 rst_n = 1'b0;
        #1;
        check("rst_ntx", 32'(bus.nTx), 32'd1);
        check("rst_d", 32'(bus.D), 32'd0);
        check("rst_tc", 32'(bus.TC), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.s_ready), 32'd0);
        repeat (2) @(posedge sys_clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // Lone requester 0, five bytes 0x11..0x15
        tick();
        bus.s_valid[0]   = 1'b1;
        bus.s_data[7:0]  = 8'h11;
        bus.s_last[0]    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            log_n[k] = bus.nTx;
            log_d[k] = bus.D;
            log_g[k] = grant;
            log_b[k] = busy;
            if (m_hs[0]) begin
                if (bus.s_last[0]) begin
                    bus.s_valid[0] = 1'b0;
                    bus.s_last[0]  = 1'b0;
                end else begin
                    bus.s_data[7:0] = bus.s_data[7:0] + 8'h01;
                    bus.s_last[0]   = (bus.s_data[7:0] == 8'h15);
                end
            end
        end
        check("t1_grant_first", 32'(log_g[0]), 32'd1);
        check("t1_ntx_first", 32'(log_n[0]), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            check("t1_ntx_low", 32'(log_n[k]), 32'd0);
            check("t1_d", 32'(log_d[k]), 32'h10 + 32'(k));
        end
        check("t1_grant_cleared", 32'(log_g[5]), 32'd0);
        check("t1_gap_busy", 32'(log_b[5]), 32'd1);
        check("t1_gap_ntx", 32'(log_n[6]), 32'd1);
        check("t1_d_hold", 32'(log_d[6]), 32'h15);
        check("t1_idle_busy", 32'(log_b[6]), 32'd0);

        // All four requesters continuous from reset: order 0,1,2,3,0 with 16 bytes each
        do_reset();
        cont_mask = '1;
        for (int i = 0; i < 8; i++) wr[i] = 0;
        pg = grant;
        for (int c = 0; c < 200 && owners.size() < 5; c++) begin
            tick();
            if (grant != 0 && pg == 0) owners.push_back(oh2i(grant));
            if (!bus.nTx && owners.size() > 0) wr[owners.size() - 1]++;
            pg = grant;
        end
        check("t2_grant_count", 32'(owners.size()), 32'd5);
        if (owners.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t2_order", 32'(owners[i]), 32'(i % NCH));
            for (int i = 0; i < 4; i++) check("t2_burst_len", 32'(wr[i]), 32'(MAX_BURST));
        end

        // nTF[1] falls during requester 1 burst
        o = -1;
        for (int a = 0; a < 6 && o != 1; a++) wait_fresh(60, o);
        check("t3_owner1", 32'(o), 32'd1);
        w = 0;
        for (int c = 0; c < 40 && w < 3; c++) begin
            tick();
            if (!bus.nTx && bus.TC == 3'd1) w++;
        end
        bus.nTF[1] = 1'b0;
        extra = 0;
        nxt   = -1;
        pg    = grant;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (!bus.nTx && bus.TC == 3'd1) extra++;
            if (grant != 0 && pg == 0) begin
                nxt = oh2i(grant);
                break;
            end
            pg = grant;
        end
        check("t3_extra_writes_le2", 32'(extra <= 2), 32'd1);
        check("t3_next_owner", 32'(nxt), 32'd2);
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (grant[1]) seen = 1'b1;
        end
        check("t3_skip_full", 32'(seen), 32'd0);
        bus.nTF[1] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (grant[1]) seen = 1'b1;
        end
        check("t3_resume", 32'(seen), 32'd1);

        // tx_en low at byte 4 of a burst
        wait_fresh(60, o);
        w = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!bus.nTx && o >= 0 && bus.TC == 3'(o)) w++;
            if (w == 4) tx_en = 1'b0;
            if (grant == 0) break;
        end
        check("t4_full_burst", 32'(w), 32'(MAX_BURST));
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (grant != 0) seen = 1'b1;
        end
        check("t4_no_grant", 32'(seen), 32'd0);
        tx_en = 1'b1;
        wait_fresh(10, nxt);
        check("t4_next_ptr", 32'(nxt), 32'((o + 1) % NCH));

        // Requester 2 drops valid after 3 bytes; requester 3 waiting
        cont_mask   = '0;
        bus.s_valid = '0;
        repeat (25) tick();
        bus.s_valid[2]     = 1'b1;
        bus.s_data[23:16]  = nb[2];
        nb[2]++;
        bus.s_last[2]      = 1'b0;
        h2  = 0;
        w   = 0;
        nxt = -1;
        pg  = grant;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (!bus.nTx && bus.TC == 3'd2) w++;
            if (m_hs[2]) begin
                h2++;
                if (h2 == 3) begin
                    bus.s_valid[2] = 1'b0;
                    cont_mask[3]   = 1'b1;
                    bus.s_valid[3] = 1'b1;
                    bus.s_data[31:24] = nb[3];
                    nb[3]++;
                    bus.s_last[3]  = 1'b0;
                end else begin
                    bus.s_data[23:16] = nb[2];
                    nb[2]++;
                end
            end
            if (h2 >= 3 && grant != 0 && pg == 0) begin
                nxt = oh2i(grant);
                break;
            end
            pg = grant;
        end
        check("t6_writes", 32'(w), 32'd3);
        check("t6_next_owner", 32'(nxt), 32'd3);

        // Reset mid-burst, then requester 0 is served first
        cont_mask = '1;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if (!bus.nTx) seen = 1'b1;
        end
        check("t5_burst_running", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_ntx", 32'(bus.nTx), 32'd1);
        check("t5_d", 32'(bus.D), 32'd0);
        check("t5_tc", 32'(bus.TC), 32'd0);
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(bus.s_ready), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_fresh(10, o);
        check("t5_first_owner", 32'(o), 32'd0);

        // Random traffic with random backpressure and enable
        cont_mask = '0;
        rnd_en    = 1'b1;
        repeat (3000) tick();
        rnd_en      = 1'b0;
        bus.s_valid = '0;
        bus.nTF     = 8'hFF;
        tx_en       = 1'b1;
        repeat (40) tick();
        check("end_sb_empty", 32'(exp_q.size()), 32'd0);
        check("end_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
